// File: rtl/obstacle_spawner_if.sv
// Spawn offer channel between obstacle_spawner and the obstacle/sprite manager.
// The spawner drives the offer; the manager answers with spawn_ready.
interface obstacle_spawner_if;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [1:0] spawn_lane;
    logic [1:0] spawn_kind;

    modport master (
        output spawn_valid,
        output spawn_lane,
        output spawn_kind,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_lane,
        input  spawn_kind,
        output spawn_ready
    );
endinterface

// File: rtl/obstacle_spawner.sv
// Turns the 4-bit LFSR value into frame-timed obstacle spawn offers (valid/ready).
// Define SPAWN_NO_REPEAT_EN to prevent two consecutive spawns in the same lane.
module obstacle_spawner #(
    parameter int MIN_GAP = 8,
    parameter int LANES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            rnd_data,
    input  logic                  frame_tick,
    input  logic                  game_en,
    obstacle_spawner_if.master    spawn,
    output logic [7:0]            spawn_count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        OFFER = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] gap_cnt;
    logic [4:0] gap_load;
    logic       valid_q;
    logic [1:0] lane_q;
    logic [1:0] kind_q;
    logic [7:0] count_q;
    logic [1:0] mapped_lane;
    logic [1:0] cap_lane;
`ifdef SPAWN_NO_REPEAT_EN
    logic [1:0] prev_lane;
`endif

    assign gap_load = 5'(MIN_GAP) + {1'b0, rnd_data};

    // Lane code 3 has no lane of its own; it folds onto the middle lane.
    always_comb begin
        mapped_lane = (rnd_data[1:0] == 2'(LANES)) ? 2'd1 : rnd_data[1:0];
        cap_lane    = mapped_lane;
`ifdef SPAWN_NO_REPEAT_EN
        if (mapped_lane == prev_lane)
            cap_lane = (mapped_lane == 2'(LANES - 1)) ? 2'd0 : mapped_lane + 2'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= 5'd0;
            valid_q <= 1'b0;
            lane_q  <= 2'd0;
            kind_q  <= 2'd0;
            count_q <= 8'd0;
`ifdef SPAWN_NO_REPEAT_EN
            prev_lane <= 2'd0;
`endif
        end else if (!game_en) begin
            // An abort still honours a handshake that lands on the same edge.
            if (state == OFFER && spawn.spawn_ready) begin
                if (count_q != 8'hFF)
                    count_q <= count_q + 8'd1;
`ifdef SPAWN_NO_REPEAT_EN
                prev_lane <= lane_q;
`endif
            end
            state   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gap_cnt <= gap_load;
                    count_q <= 8'd0;
`ifdef SPAWN_NO_REPEAT_EN
                    prev_lane <= 2'd0;
`endif
                    state   <= WAIT;
                end
                WAIT: begin
                    if (frame_tick) begin
                        if (gap_cnt > 5'd1) begin
                            gap_cnt <= gap_cnt - 5'd1;
                        end else begin
                            lane_q  <= cap_lane;
                            kind_q  <= rnd_data[3:2];
                            valid_q <= 1'b1;
                            state   <= OFFER;
                        end
                    end
                end
                OFFER: begin
                    // Gap is frozen while the manager applies backpressure.
                    if (spawn.spawn_ready) begin
                        if (count_q != 8'hFF)
                            count_q <= count_q + 8'd1;
`ifdef SPAWN_NO_REPEAT_EN
                        prev_lane <= lane_q;
`endif
                        gap_cnt <= gap_load;
                        valid_q <= 1'b0;
                        state   <= WAIT;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign spawn.spawn_valid = valid_q;
    assign spawn.spawn_lane  = lane_q;
    assign spawn.spawn_kind  = kind_q;
    assign spawn_count       = count_q;
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed self-checking bench for obstacle_spawner (default MIN_GAP=8).
// Lane expectations follow SPAWN_NO_REPEAT_EN when it is defined.
module tb_obstacle_spawner;

    logic       clk;
    logic       rst_n;
    logic [3:0] rnd_data;
    logic       frame_tick;
    logic       game_en;
    logic [7:0] spawn_count;
    logic       busy;

    int n_asserts = 0;
    int n_fails   = 0;
    int tb_count  = 0;
`ifdef SPAWN_NO_REPEAT_EN
    logic [1:0] tb_prev = 2'd0;
`endif

    obstacle_spawner_if sif ();

    obstacle_spawner #(.MIN_GAP(8), .LANES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rnd_data    (rnd_data),
        .frame_tick  (frame_tick),
        .game_en     (game_en),
        .spawn       (sif.master),
        .spawn_count (spawn_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic apply_stimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [1:0] map_lane(input logic [1:0] r);
        return (r == 2'd3) ? 2'd1 : r;
    endfunction

    function automatic logic [1:0] exp_lane(input logic [1:0] mapped);
`ifdef SPAWN_NO_REPEAT_EN
        if (mapped == tb_prev)
            return (mapped == 2'd2) ? 2'd0 : mapped + 2'd1;
`endif
        return mapped;
    endfunction

    task automatic note_accept(input logic [1:0] lane);
`ifdef SPAWN_NO_REPEAT_EN
        tb_prev = lane;
`else
        if (lane > 2'd2) $display("[TB] lane out of range");
`endif
        if (tb_count != 255) tb_count++;
    endtask

    task automatic note_restart();
`ifdef SPAWN_NO_REPEAT_EN
        tb_prev = 2'd0;
`endif
        tb_count = 0;
    endtask

    // Runs back-to-back frame ticks until the offer appears, checking its timing and contents.
    task automatic reach_offer(input logic [3:0] cap, input int gap, output logic [1:0] lane);
        for (int i = 0; i < gap - 1; i++) begin
            frame_tick = 1'b1;
            rnd_data   = 4'd0;
            apply_stimulus();
        end
        frame_tick = 1'b0;
        check_output("pre_capture_valid", {7'd0, sif.spawn_valid}, 8'd0);
        frame_tick = 1'b1;
        rnd_data   = cap;
        apply_stimulus();
        frame_tick = 1'b0;
        rnd_data   = 4'd0;
        lane = exp_lane(map_lane(cap[1:0]));
        check_output("offer_valid", {7'd0, sif.spawn_valid}, 8'd1);
        check_output("offer_lane", {6'd0, sif.spawn_lane}, {6'd0, lane});
        check_output("offer_kind", {6'd0, sif.spawn_kind}, {6'd0, cap[3:2]});
    endtask

    task automatic do_spawn(input logic [3:0] cap);
        logic [1:0] lane;
        reach_offer(cap, 8, lane);
        sif.spawn_ready = 1'b1;
        rnd_data        = 4'd0;
        apply_stimulus();
        sif.spawn_ready = 1'b0;
        note_accept(lane);
        check_output("accept_valid", {7'd0, sif.spawn_valid}, 8'd0);
        check_output("accept_count", spawn_count, 8'(tb_count));
    endtask

    initial begin
        logic [1:0] lane;
        rst_n           = 1'b0;
        game_en         = 1'b0;
        frame_tick      = 1'b0;
        rnd_data        = 4'd0;
        sif.spawn_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_valid", {7'd0, sif.spawn_valid}, 8'd0);
        check_output("reset_lane", {6'd0, sif.spawn_lane}, 8'd0);
        check_output("reset_kind", {6'd0, sif.spawn_kind}, 8'd0);
        check_output("reset_count", spawn_count, 8'd0);
        check_output("reset_busy", {7'd0, busy}, 8'd0);

        rst_n      = 1'b1;
        frame_tick = 1'b1;
        apply_stimulus();
        check_output("idle_no_game_busy", {7'd0, busy}, 8'd0);

        // Game start with rnd 5 gives a 13-frame gap; the start-cycle tick is not counted.
        game_en    = 1'b1;
        rnd_data   = 4'h5;
        frame_tick = 1'b1;
        apply_stimulus();
        frame_tick = 1'b0;
        rnd_data   = 4'd0;
        check_output("start_busy", {7'd0, busy}, 8'd1);
        check_output("start_valid", {7'd0, sif.spawn_valid}, 8'd0);
        for (int i = 0; i < 12; i++) begin
            frame_tick = 1'b1;
            apply_stimulus();
            frame_tick = 1'b0;
            apply_stimulus();
        end
        check_output("gap12_valid", {7'd0, sif.spawn_valid}, 8'd0);
        rnd_data   = 4'b1110;
        frame_tick = 1'b1;
        apply_stimulus();
        frame_tick = 1'b0;
        rnd_data   = 4'd0;
        check_output("gap13_valid", {7'd0, sif.spawn_valid}, 8'd1);
        check_output("gap13_lane", {6'd0, sif.spawn_lane}, 8'd2);
        check_output("gap13_kind", {6'd0, sif.spawn_kind}, 8'd3);

        // Backpressure: 20 clocks with ready low and three frame ticks.
        for (int i = 0; i < 20; i++) begin
            frame_tick = (i == 3 || i == 9 || i == 15);
            rnd_data   = 4'(i);
            apply_stimulus();
        end
        frame_tick = 1'b0;
        check_output("bp_valid", {7'd0, sif.spawn_valid}, 8'd1);
        check_output("bp_lane", {6'd0, sif.spawn_lane}, 8'd2);
        check_output("bp_kind", {6'd0, sif.spawn_kind}, 8'd3);
        check_output("bp_count", spawn_count, 8'd0);
        sif.spawn_ready = 1'b1;
        rnd_data        = 4'd0;
        apply_stimulus();
        sif.spawn_ready = 1'b0;
        note_accept(2'd2);
        check_output("bp_accept_valid", {7'd0, sif.spawn_valid}, 8'd0);
        check_output("bp_accept_count", spawn_count, 8'd1);
        check_output("bp_accept_busy", {7'd0, busy}, 8'd1);

        // Lane code 3 folds onto lane 1.
        do_spawn(4'b0111);
        check_output("fold_count", spawn_count, 8'd2);

        for (int k = 0; k < 255; k++) do_spawn(4'(k));
        check_output("saturated_count", spawn_count, 8'd255);

        // Abort during an offer: valid drops, count and offer fields hold.
        reach_offer(4'b1000, 8, lane);
        game_en = 1'b0;
        apply_stimulus();
        check_output("abort_valid", {7'd0, sif.spawn_valid}, 8'd0);
        check_output("abort_busy", {7'd0, busy}, 8'd0);
        check_output("abort_count", spawn_count, 8'd255);
        check_output("abort_lane", {6'd0, sif.spawn_lane}, {6'd0, lane});
        check_output("abort_kind", {6'd0, sif.spawn_kind}, 8'd2);
        game_en = 1'b1;
        apply_stimulus();
        note_restart();
        check_output("restart_count", spawn_count, 8'd0);
        check_output("restart_busy", {7'd0, busy}, 8'd1);

        // Game end coinciding with a handshake still counts the spawn.
        reach_offer(4'b1001, 8, lane);
        game_en         = 1'b0;
        sif.spawn_ready = 1'b1;
        apply_stimulus();
        sif.spawn_ready = 1'b0;
        check_output("end_hs_count", spawn_count, 8'd1);
        check_output("end_hs_valid", {7'd0, sif.spawn_valid}, 8'd0);
        check_output("end_hs_busy", {7'd0, busy}, 8'd0);
        game_en = 1'b1;
        apply_stimulus();
        note_restart();
        check_output("restart2_count", spawn_count, 8'd0);

        // Two captures with lane code 2 in a row.
        do_spawn(4'b0010);
        reach_offer(4'b0110, 8, lane);
`ifdef SPAWN_NO_REPEAT_EN
        check_output("repeat_second_lane", {6'd0, sif.spawn_lane}, 8'd0);
`else
        check_output("repeat_second_lane", {6'd0, sif.spawn_lane}, 8'd2);
`endif

        // Reset mid-offer clears everything without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midreset_valid", {7'd0, sif.spawn_valid}, 8'd0);
        check_output("midreset_lane", {6'd0, sif.spawn_lane}, 8'd0);
        check_output("midreset_kind", {6'd0, sif.spawn_kind}, 8'd0);
        check_output("midreset_count", spawn_count, 8'd0);
        check_output("midreset_busy", {7'd0, busy}, 8'd0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
